ram_march_tester: RTL

Built-in self-test sequencer that sits directly upstream of the single-port synchronous RAM and drives its address, data_in, cs, we and oe pins. It consumes the RAM's data_out. On a start request it runs a four-phase march: write, read-verify, write-complement descending, read-verify descending. It then reports pass/fail, the first failing address and data, and a saturating error count.

---
 rtl/ram_march_tester.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ram_march_tester.sv
// ram_march_tester: four-phase march BIST sequencer for a single-port
// synchronous RAM (W0 up, R0 up, W1 down with complement, R1 down).
// Ports: clk, rst (async, active high), start (level, sampled in IDLE);
//   status busy, done (1-cycle pulse), pass, err_count (saturating),
//   fail_addr / fail_data (first mismatch);
//   RAM side ram_address, ram_data_in, ram_cs, ram_we, ram_oe driven out,
//   ram_data_out read back.
// Option: define ADDR_PATTERN_EN to XOR the address into the test word.
module ram_march_tester #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55,
    parameter int                    ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

`ifdef ADDR_PATTERN_EN
    localparam bit ADDR_MIX = 1'b1;
`else
    localparam bit ADDR_MIX = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    // Read phases last D+1 cycles: the extra cycle drains the RAM's
    // registered output for the final address.
    localparam logic [ADDR_WIDTH:0] RD_LAST = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0,
        W1,
        R1,
        FIN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic [DATA_WIDTH-1:0] exp_word;
    logic                  mismatch;

    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [DATA_WIDTH-1:0] ext;
        ext = DATA_WIDTH'(a);
        pat = ADDR_MIX ? (PATTERN ^ ext) : PATTERN;
    endfunction

    // Read data arriving this cycle belongs to last cycle's address.
    always_comb begin
        exp_word = pat(prev_addr);
        if (state == R1) begin
            exp_word = ~pat(prev_addr);
        end
        mismatch = 1'b0;
        if ((state == R0 || state == R1) && cnt != '0) begin
            mismatch = (ram_data_out != exp_word);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_addr   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
        end else begin
            done      <= 1'b0;
            prev_addr <= ram_address;
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (err_count == '0) begin
                    fail_addr <= prev_addr;
                    fail_data <= ram_data_out;
                end
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= W0;
                        busy        <= 1'b1;
                        ram_cs      <= 1'b1;
                        ram_we      <= 1'b1;
                        ram_oe      <= 1'b0;
                        ram_address <= '0;
                        ram_data_in <= pat('0);
                        err_count   <= '0;
                        fail_addr   <= '0;
                        fail_data   <= '0;
                        pass        <= 1'b0;
                    end
                end
                W0: begin
                    if (ram_address == LAST_ADDR) begin
                        state       <= R0;
                        cnt         <= '0;
                        ram_we      <= 1'b0;
                        ram_oe      <= 1'b1;
                        ram_address <= '0;
                        ram_data_in <= '0;
                    end else begin
                        ram_address <= ram_address + 1'b1;
                        ram_data_in <= pat(ram_address + 1'b1);
                    end
                end
                R0: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == RD_LAST) begin
                        state       <= W1;
                        ram_we      <= 1'b1;
                        ram_oe      <= 1'b0;
                        ram_address <= LAST_ADDR;
                        ram_data_in <= ~pat(LAST_ADDR);
                    end else if (ram_address != LAST_ADDR) begin
                        ram_address <= ram_address + 1'b1;
                    end
                end
                W1: begin
                    if (ram_address == '0) begin
                        state       <= R1;
                        cnt         <= '0;
                        ram_we      <= 1'b0;
                        ram_oe      <= 1'b1;
                        ram_address <= LAST_ADDR;
                        ram_data_in <= '0;
                    end else begin
                        ram_address <= ram_address - 1'b1;
                        ram_data_in <= ~pat(ram_address - 1'b1);
                    end
                end
                R1: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == RD_LAST) begin
                        state       <= FIN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        ram_cs      <= 1'b0;
                        ram_oe      <= 1'b0;
                        ram_address <= '0;
                        // Fold in this edge's compare, which also lands now.
                        pass        <= (err_count == '0) && !mismatch;
                    end else if (ram_address != '0) begin
                        ram_address <= ram_address - 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
